// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: bus initiator that block-copies (read then write) or block-fills a wrapping address range.
// Latency: copy of L words finishes with done in cycle 2L+1 after start; fill finishes with done in cycle L+1.
// Backpressure: none; the external arbiter grants the memory port while busy is high, and start is ignored unless IDLE.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   start, mode       request pulse (accepted only in IDLE); 0 = copy, 1 = fill
//   src_addr,dst_addr first source / destination word address (latched on accept)
//   length            word count 0..2^AW (latched on accept)
//   fill_value        constant written in fill mode (latched on accept)
//   busy, done        transfer in progress; one-cycle completion pulse
//   words_done        words written in the current or last transfer
//   mem_addr, mem_wdata, mem_we, mem_rdata   single-port data memory master (registered read)

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module dmem_copy_engine #(
  parameter int DW = `DSIZE,
  parameter int AW = `MEM_SPACE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   length,
  input  logic [DW-1:0] fill_value,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   words_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        r_state;
  state_t        w_next;
  logic          r_mode;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_cnt;
  logic [AW:0]   r_words;
  logic [DW-1:0] r_fill;
  logic          w_accept;
  logic          w_we_raw;

  // Next-state and memory-port outputs; everything is decoded from the
  // current state so the port is fully quiet outside READ/WRITE.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_we_raw  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (length == '0)  w_next = S_DONE;
          else if (mode)     w_next = S_WRITE;
          else               w_next = S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = r_src;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_addr = r_dst;
        w_we_raw = 1'b1;
        // Registered read issued in the preceding READ cycle lands here.
        mem_wdata = r_mode ? r_fill : mem_rdata;
        if (r_cnt == CNT_ONE) w_next = S_DONE;
        else if (!r_mode)     w_next = S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset is also an abort, so the write strobe must die combinationally
  // in the very cycle reset is low, not one edge later.
  assign mem_we     = w_we_raw & rst;
  assign words_done = r_words;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_words <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode  <= mode;
        r_src   <= src_addr;
        r_dst   <= dst_addr;
        r_cnt   <= length;
        r_fill  <= fill_value;
        r_words <= '0;
      end
      if (r_state == S_READ) begin
        r_src <= r_src + (AW)'(1);
      end
      if (r_state == S_WRITE) begin
        r_dst   <= r_dst + (AW)'(1);
        r_cnt   <= r_cnt - CNT_ONE;
        r_words <= r_words + CNT_ONE;
      end
    end
  end

endmodule
